// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte FIFO plus 8N1 serializer for the core's UART write port
module uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           uart_din,
  input  logic                  uart_we,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         baud_cnt, baud_nx;
  logic [2:0]            bit_idx, bit_nx;
  logic [7:0]            shift, shift_nx;
  logic                  txd_nx;
  logic                  pop, push, empty, baud_last;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  assign empty      = (count == '0);
  assign fifo_full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE) || !empty;
  assign baud_last  = (baud_cnt == CW'(CLK_DIV - 1));
  // A pop on a full FIFO frees the slot the same cycle, so that write is kept.
  assign push       = uart_we && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_din[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (uart_we && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shift    <= shift_nx;
      txd      <= txd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + CW'(1);
    bit_nx   = bit_idx;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        baud_nx = '0;
        if (!empty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          state_nx = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_nx  = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_nx  = '0;
          shift_nx = shift >> 1;
          bit_nx   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_nx = '0;
          if (!empty) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level follows the current state one cycle later, keeping txd a clean flop output.
  always_comb begin
    txd_nx = 1'b1;
    if (state == START)     txd_nx = 1'b0;
    else if (state == DATA) txd_nx = shift[0];
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, we_a, we_b;
  logic [31:0] din_a, din_b;
  logic        txd_a, txd_b, busy_a, busy_b, full_a, full_b, ovf_a, ovf_b;
  logic [4:0]  cnt_a;
  logic [2:0]  cnt_b;

  uart_tx #(.CLK_DIV(4), .DEPTH_LOG2(4)) dut_a (
    .clk(clk), .reset(rst_a), .uart_din(din_a), .uart_we(we_a), .txd(txd_a),
    .tx_busy(busy_a), .fifo_full(full_a), .fifo_count(cnt_a), .overflow(ovf_a)
  );

  uart_tx #(.CLK_DIV(8), .DEPTH_LOG2(2)) dut_b (
    .clk(clk), .reset(rst_b), .uart_din(din_b), .uart_we(we_b), .txd(txd_b),
    .tx_busy(busy_b), .fifo_full(full_b), .fifo_count(cnt_b), .overflow(ovf_b)
  );

  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  longint     start_a[$];
  bit         in_frame[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic get_txd(input int w);
    return (w != 0) ? txd_b : txd_a;
  endfunction

  function automatic logic get_rst(input int w);
    return (w != 0) ? rst_b : rst_a;
  endfunction

  function automatic logic get_busy(input int w);
    return (w != 0) ? busy_b : busy_a;
  endfunction

  function automatic int exp_size(input int w);
    return (w != 0) ? exp_b.size() : exp_a.size();
  endfunction

  // Receives one frame whose start bit was seen at this negedge and checks every sample.
  task automatic rx_frame(input int w, input int div);
    logic [7:0] e, rx;
    logic       t, lvl;
    bit         bad, aborted, have;
    int         b;
    in_frame[w] = 1'b1;
    if (w == 0) start_a.push_back(cyc);
    have = (exp_size(w) != 0);
    e = 8'h00;
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame_%0d actual=frame required=none", w);
    end else begin
      e = (w != 0) ? exp_b.pop_front() : exp_a.pop_front();
    end
    rx = 8'h00;
    bad = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < 10 * div; i++) begin
      if (i > 0) @(negedge clk);
      if (get_rst(w) !== 1'b1) begin
        aborted = 1'b1;
        break;
      end
      t = get_txd(w);
      b = i / div;
      lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b-1];
      if (t !== lvl) bad = 1'b1;
      if (b >= 1 && b <= 8 && (i % div) == div / 2) rx[b-1] = t;
    end
    if (have && !aborted) chk($sformatf("frame_%0d", w), {23'd0, bad, rx}, {24'd0, e});
    in_frame[w] = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_a === 1'b1 && txd_a === 1'b0) rx_frame(0, 4);
  end

  initial forever begin
    @(negedge clk);
    if (rst_b === 1'b1 && txd_b === 1'b0) rx_frame(1, 8);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int w, input logic [31:0] d, input bit acc);
    if (w != 0) begin
      din_b = d;
      we_b = 1'b1;
      if (acc) exp_b.push_back(d[7:0]);
    end else begin
      din_a = d;
      we_a = 1'b1;
      if (acc) exp_a.push_back(d[7:0]);
    end
    @(posedge clk);
    #1;
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic drain(input int w);
    int n = 0;
    while (n < 3000 && (get_busy(w) || in_frame[w] || exp_size(w) != 0)) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_in_time_%0d", w), 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    we_a = 1'b0;  we_b = 1'b0;
    din_a = '0;   din_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd_a", 32'(txd_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_full_a", 32'(full_a), 32'd0);
    chk("rst_count_a", 32'(cnt_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_txd_b", 32'(txd_b), 32'd1);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_full_b", 32'(full_b), 32'd0);
    chk("rst_count_b", 32'(cnt_b), 32'd0);
    chk("rst_ovf_b", 32'(ovf_b), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    // single byte: latency and busy window
    sync();
    wr(0, 32'h0000_00A5, 1);
    @(negedge clk);
    chk("lat_count_n1", 32'(cnt_a), 32'd1);
    chk("lat_busy_n1", 32'(busy_a), 32'd1);
    @(negedge clk);
    chk("lat_txd_n2", 32'(txd_a), 32'd1);
    @(negedge clk);
    chk("lat_txd_n3", 32'(txd_a), 32'd0);
    repeat (38) @(negedge clk);
    chk("busy_last_stop", 32'(busy_a), 32'd1);
    @(negedge clk);
    chk("busy_after_frame", 32'(busy_a), 32'd0);
    drain(0);

    // upper data bits ignored
    sync();
    wr(0, 32'hFFFF_FF3C, 1);
    drain(0);

    // back-to-back frames
    sync();
    start_a.delete();
    wr(0, 32'h11, 1);
    wr(0, 32'h22, 1);
    wr(0, 32'h33, 1);
    @(negedge clk);
    chk("b2b_count", 32'(cnt_a), 32'd2);
    drain(0);
    chk("b2b_frames", 32'(start_a.size()), 32'd3);
    if (start_a.size() >= 3) begin
      chk("b2b_gap1", 32'(start_a[1] - start_a[0]), 32'd40);
      chk("b2b_gap2", 32'(start_a[2] - start_a[1]), 32'd40);
    end

    // overflow on a 4-deep FIFO
    sync();
    for (int i = 1; i <= 5; i++) wr(1, 32'(i), 1);
    chk("ovf_full", 32'(full_b), 32'd1);
    chk("ovf_count_full", 32'(cnt_b), 32'd4);
    chk("ovf_before_drop", 32'(ovf_b), 32'd0);
    wr(1, 32'h06, 0);
    chk("ovf_set", 32'(ovf_b), 32'd1);
    chk("ovf_count_kept", 32'(cnt_b), 32'd4);
    drain(1);
    chk("ovf_sticky", 32'(ovf_b), 32'd1);
    chk("ovf_drained_count", 32'(cnt_b), 32'd0);
    chk("ovf_drained_full", 32'(full_b), 32'd0);

    // write on the pop cycle of a full FIFO is kept
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("ovf_cleared_by_reset", 32'(ovf_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    sync();
    for (int i = 1; i <= 5; i++) wr(1, 32'h40 + 32'(i), 1);
    repeat (76) @(posedge clk);
    #1;
    chk("pop_cycle_count_before", 32'(cnt_b), 32'd4);
    wr(1, 32'h77, 1);
    chk("pop_cycle_count_after", 32'(cnt_b), 32'd4);
    chk("pop_cycle_full", 32'(full_b), 32'd1);
    chk("pop_cycle_ovf", 32'(ovf_b), 32'd0);
    drain(1);

    // reset mid-frame discards everything
    sync();
    wr(0, 32'h0F, 1);
    wr(0, 32'hAA, 1);
    wr(0, 32'hBB, 1);
    repeat (17) @(negedge clk);
    chk("abort_count_before", 32'(cnt_a), 32'd2);
    chk("abort_bit3_level", 32'(txd_a), 32'd1);
    #2;
    rst_a = 1'b0;
    exp_a.delete();
    #1;
    chk("abort_txd", 32'(txd_a), 32'd1);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_count", 32'(cnt_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_quiet_busy", 32'(busy_a), 32'd0);
    chk("abort_quiet_count", 32'(cnt_a), 32'd0);
    chk("abort_quiet_txd", 32'(txd_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
